nibbler_run_ctrl: RTL and testbench

- Run/halt/single-step sequencer for the 4-bit Nibbler CPU.
- Produces one clock-enable, `cpu_en`, which gates the PC counter, fetch register, phase flop, flags, accumulator and output port.
- A debug command port can run, halt and step the core N instructions, and set one PC breakpoint.
- Stops only on instruction boundaries. Keeps a retired-instruction counter.

---
 rtl/nibbler_dbg_pkg.sv | 25 ++
 rtl/nibbler_run_ctrl_if.sv | 14 +
 rtl/nibbler_bp_match.sv | 33 +++
 rtl/nibbler_run_ctrl.sv | 133 +++++++++++++
 tb/tb_nibbler_run_ctrl.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nibbler_dbg_pkg.sv
// Shared definitions for the Nibbler debug/run controller: command codes,
// sequencer states and default widths.
package nibbler_dbg_pkg;

  localparam int DEF_PC_W   = 12;
  localparam int DEF_STEP_W = 8;
  localparam int DEF_CNT_W  = 16;

  localparam logic [2:0] CMD_NOP    = 3'd0;
  localparam logic [2:0] CMD_RUN    = 3'd1;
  localparam logic [2:0] CMD_HALT   = 3'd2;
  localparam logic [2:0] CMD_STEP   = 3'd3;
  localparam logic [2:0] CMD_SET_BP = 3'd4;
  localparam logic [2:0] CMD_CLR_BP = 3'd5;
  localparam logic [2:0] CMD_CLR_CNT = 3'd6;

  typedef enum logic [2:0] {
    HALT     = 3'd0,
    RUN      = 3'd1,
    STOPPING = 3'd2,
    STEP     = 3'd3,
    BRK      = 3'd4
  } run_state_t;

endpackage

// File: rtl/nibbler_run_ctrl_if.sv
// Debug command port of the Nibbler run controller.
interface nibbler_run_ctrl_if #(
  parameter int PC_W = nibbler_dbg_pkg::DEF_PC_W
) ();

  logic            cmd_valid;
  logic [2:0]      cmd;
  logic [PC_W-1:0] cmd_arg;
  logic            cmd_ready;

  modport master (output cmd_valid, output cmd, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd, input cmd_arg, output cmd_ready);

endinterface

// File: rtl/nibbler_bp_match.sv
// Single PC breakpoint: address register, enable flag and equality match.
module nibbler_bp_match #(
  parameter int PC_W = nibbler_dbg_pkg::DEF_PC_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            i_set,
  input  logic            i_clr,
  input  logic [PC_W-1:0] i_addr,
  input  logic [PC_W-1:0] i_pc,
  output logic            o_en,
  output logic            o_match
);

  logic            r_bp_en;
  logic [PC_W-1:0] r_bp_addr;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bp_en   <= 1'b0;
      r_bp_addr <= '0;
    end else if (i_set) begin
      r_bp_en   <= 1'b1;
      r_bp_addr <= i_addr;
    end else if (i_clr) begin
      r_bp_en   <= 1'b0;
    end
  end

  assign o_en    = r_bp_en;
  assign o_match = r_bp_en && (i_pc == r_bp_addr);

endmodule

// File: rtl/nibbler_run_ctrl.sv
// Run/halt/single-step sequencer for the Nibbler CPU; gates the core through
// cpu_en and only ever stops it on an instruction boundary (phase=0).
module nibbler_run_ctrl
  import nibbler_dbg_pkg::*;
#(
  parameter int PC_W         = DEF_PC_W,
  parameter int STEP_W       = DEF_STEP_W,
  parameter int CNT_W        = DEF_CNT_W,
  parameter bit RUN_ON_RESET = 1'b0
) (
  input  logic                clock,
  input  logic                reset,
  nibbler_run_ctrl_if.slave   dbg,
  input  logic [PC_W-1:0]     pc,
  input  logic                phase,
  output logic                cpu_en,
  output logic                halted,
  output logic                bp_hit,
  output logic [CNT_W-1:0]    retired
);

  localparam run_state_t          RESET_STATE = run_state_t'(RUN_ON_RESET ? RUN : HALT);
  localparam logic [STEP_W-1:0]   STEP_ONE    = STEP_W'(1);

  run_state_t        r_state;
  logic [STEP_W-1:0] r_step_rem;
  logic              r_skip_bp;
  logic [CNT_W-1:0]  r_retired;

  logic              w_ready;
  logic              w_accept;
  logic              w_bp_en;
  logic              w_bp_match;
  logic              w_bp_stop;
  logic              w_retire;
  logic [STEP_W-1:0] w_step_arg;
  logic [STEP_W-1:0] w_step_load;

  assign w_ready       = (r_state == HALT) || (r_state == BRK) || (r_state == RUN);
  assign dbg.cmd_ready = w_ready;
  assign w_accept      = dbg.cmd_valid && w_ready;

  nibbler_bp_match #(.PC_W(PC_W)) u_bp (
    .clock   (clock),
    .reset   (reset),
    .i_set   (w_accept && (dbg.cmd == CMD_SET_BP)),
    .i_clr   (w_accept && (dbg.cmd == CMD_CLR_BP)),
    .i_addr  (dbg.cmd_arg),
    .i_pc    (pc),
    .o_en    (w_bp_en),
    .o_match (w_bp_match)
  );

  // Breakpoints are only honoured while free-running, at a fetch boundary.
  assign w_bp_stop   = (r_state == RUN) && !phase && w_bp_match && !r_skip_bp;
  assign w_step_arg  = dbg.cmd_arg[STEP_W-1:0];
  assign w_step_load = (w_step_arg == '0) ? STEP_ONE : w_step_arg;

  always_comb begin
    cpu_en = 1'b0;
    unique case (r_state)
      HALT, BRK: cpu_en = 1'b0;
      RUN:       cpu_en = !w_bp_stop;
      STOPPING:  cpu_en = phase;
      STEP:      cpu_en = phase || (r_step_rem != '0);
      default:   cpu_en = 1'b0;
    endcase
  end

  assign w_retire = cpu_en && phase;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= RESET_STATE;
      r_step_rem <= '0;
      r_skip_bp  <= 1'b0;
    end else begin
      if (cpu_en && !phase) begin
        r_skip_bp <= 1'b0;
      end
      unique case (r_state)
        HALT, BRK: begin
          if (w_accept) begin
            if (dbg.cmd == CMD_RUN) begin
              r_state   <= RUN;
              r_skip_bp <= 1'b1;
            end else if (dbg.cmd == CMD_HALT) begin
              r_state <= HALT;
            end else if (dbg.cmd == CMD_STEP) begin
              r_state    <= STEP;
              r_step_rem <= w_step_load;
            end
          end
        end
        RUN: begin
          if (w_bp_stop) begin
            r_state <= BRK;
          end else if (w_accept && (dbg.cmd == CMD_HALT)) begin
            r_state <= STOPPING;
          end
        end
        STOPPING: begin
          if (!phase) begin
            r_state <= HALT;
          end
        end
        STEP: begin
          if (!phase && (r_step_rem == '0)) begin
            r_state <= HALT;
          end else if (w_retire) begin
            r_step_rem <= r_step_rem - 1'b1;
          end
        end
        default: r_state <= HALT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (w_accept && (dbg.cmd == CMD_CLR_CNT)) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + 1'b1;
    end
  end

  assign retired = r_retired;
  assign halted  = (r_state == HALT) || (r_state == BRK);
  assign bp_hit  = (r_state == BRK);

endmodule

// File: tb/tb_nibbler_run_ctrl.sv
// Bench for nibbler_run_ctrl: a toy CPU drives pc/phase, a per-cycle
// behavioural model predicts every output, directed scenarios add fixed checks.
module tb_nibbler_run_ctrl;

  localparam int PC_W   = 12;
  localparam int STEP_W = 8;
  localparam int CNT_W  = 16;

  localparam logic [2:0] C_RUN     = 3'd1;
  localparam logic [2:0] C_HALT    = 3'd2;
  localparam logic [2:0] C_STEP    = 3'd3;
  localparam logic [2:0] C_SET_BP  = 3'd4;
  localparam logic [2:0] C_CLR_BP  = 3'd5;
  localparam logic [2:0] C_CLR_CNT = 3'd6;

  localparam int M_IDLE     = 0;
  localparam int M_FREE     = 1;
  localparam int M_STEPPING = 2;
  localparam int M_PARKED   = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  nibbler_run_ctrl_if #(.PC_W(PC_W)) dbg ();

  logic [PC_W-1:0]  pc;
  logic             phase;
  logic             cpu_en;
  logic             halted;
  logic             bp_hit;
  logic [CNT_W-1:0] retired;

  nibbler_run_ctrl #(
    .PC_W        (PC_W),
    .STEP_W      (STEP_W),
    .CNT_W       (CNT_W),
    .RUN_ON_RESET(1'b0)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .dbg    (dbg),
    .pc     (pc),
    .phase  (phase),
    .cpu_en (cpu_en),
    .halted (halted),
    .bp_hit (bp_hit),
    .retired(retired)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  bit jumpy    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Toy CPU: phase toggles on enabled edges, pc advances after execute.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      phase <= 1'b0;
    end else if (cpu_en) begin
      phase <= ~phase;
      if (phase) begin
        if (jumpy && ($urandom_range(3) == 0))
          pc <= PC_W'($urandom_range(15));
        else if (jumpy)
          pc <= (pc + 1'b1) & PC_W'(15);
        else
          pc <= pc + 1'b1;
      end
    end
  end

  // Reference model state
  int               m_mode;
  bit               m_stop, m_skip, m_bp_on;
  logic [PC_W-1:0]  m_bp_at;
  int               m_left;
  logic [CNT_W-1:0] m_count;

  always @(negedge clock) begin : model
    bit acc, e_en, e_ready, fire, e_halted;
    int nxt;
    if (!reset) begin
      chk("rst_cpu_en", cpu_en, 0);
      chk("rst_halted", halted, 1);
      chk("rst_bp_hit", bp_hit, 0);
      chk("rst_retired", retired, 0);
      m_mode = M_IDLE; m_stop = 0; m_skip = 0; m_bp_on = 0;
      m_bp_at = '0; m_left = 0; m_count = '0;
    end else begin
      e_ready  = !((m_mode == M_STEPPING) || (m_mode == M_FREE && m_stop));
      acc      = dbg.cmd_valid && e_ready;
      fire     = 0;
      nxt      = m_mode;
      e_en     = 0;
      e_halted = (m_mode == M_IDLE) || (m_mode == M_PARKED);
      if (m_mode == M_FREE) begin
        if (!phase && m_stop) begin
          nxt = M_IDLE; m_stop = 0;
        end else if (!phase && m_bp_on && pc == m_bp_at && !m_skip) begin
          fire = 1; nxt = M_PARKED;
        end else begin
          e_en = 1;
        end
      end else if (m_mode == M_STEPPING) begin
        e_en = phase || (m_left != 0);
        if (!e_en) nxt = M_IDLE;
      end
      chk("cpu_en", cpu_en, e_en);
      chk("halted", halted, e_halted);
      chk("bp_hit", bp_hit, m_mode == M_PARKED);
      chk("cmd_ready", dbg.cmd_ready, e_ready);
      chk("retired", retired, m_count);
      en_cnt = en_cnt + (cpu_en ? 1 : 0);
      if (e_en && !phase) m_skip = 0;
      if (e_en && phase && m_mode == M_STEPPING) m_left--;
      if (acc && dbg.cmd == C_CLR_CNT) m_count = '0;
      else if (e_en && phase) m_count = m_count + 1'b1;
      if (acc) begin
        case (dbg.cmd)
          C_RUN: if (e_halted) begin nxt = M_FREE; m_skip = 1; m_stop = 0; end
          C_HALT: begin
            if (m_mode == M_FREE && !fire) m_stop = 1;
            if (e_halted) nxt = M_IDLE;
          end
          C_STEP: if (e_halted) begin
            nxt = M_STEPPING;
            m_left = (dbg.cmd_arg[STEP_W-1:0] == 0) ? 1 : int'(dbg.cmd_arg[STEP_W-1:0]);
          end
          C_SET_BP: begin m_bp_on = 1; m_bp_at = dbg.cmd_arg; end
          C_CLR_BP: m_bp_on = 0;
          default: ;
        endcase
      end
      m_mode = nxt;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input logic [2:0] c, input logic [PC_W-1:0] a);
    dbg.cmd_valid = 1'b1; dbg.cmd = c; dbg.cmd_arg = a;
    tick(1);
    dbg.cmd_valid = 1'b0; dbg.cmd = '0;
  endtask

  task automatic wait_halted(input string tag, input int budget);
    int k = 0;
    while (!halted && k < budget) begin tick(1); k++; end
    chk({tag, "_halt_to"}, halted, 1);
  endtask

  task automatic wait_phase(input logic ph, input int budget);
    int k = 0;
    while (phase !== ph && k < budget) begin tick(1); k++; end
    chk("phase_wait_to", phase, ph);
  endtask

  initial begin
    int e0;
    int k;
    logic [CNT_W-1:0] r0;
    logic [2:0] c;
    logic [PC_W-1:0] a;
    dbg.cmd_valid = 1'b0; dbg.cmd = '0; dbg.cmd_arg = '0;
    tick(3);
    chk("reset_halted", halted, 1);
    chk("reset_cpu_en", cpu_en, 0);
    chk("reset_retired", retired, 0);
    reset = 1'b1;
    e0 = en_cnt;
    tick(10);
    chk("idle_en_cycles", en_cnt - e0, 0);
    chk("idle_phase", phase, 0);

    e0 = en_cnt;
    send(C_STEP, 12'd3);
    wait_halted("step3", 40);
    chk("step3_en_cycles", en_cnt - e0, 6);
    chk("step3_phase", phase, 0);
    chk("step3_retired", retired, 3);
    e0 = en_cnt;
    send(C_STEP, 12'h700);
    wait_halted("step0", 40);
    chk("step0_en_cycles", en_cnt - e0, 2);
    chk("step0_retired", retired, 4);

    reset = 1'b0; tick(1); reset = 1'b1; tick(1);
    send(C_SET_BP, 12'h005);
    send(C_RUN, '0);
    k = 0;
    while (!bp_hit && k < 60) begin tick(1); k++; end
    chk("brk_bp_hit", bp_hit, 1);
    chk("brk_pc", pc, 12'h005);
    chk("brk_phase", phase, 0);
    chk("brk_cpu_en", cpu_en, 0);
    send(C_RUN, '0);
    tick(4);
    chk("resume_left_bp", pc != 12'h005, 1);
    chk("resume_no_rebrk", bp_hit, 0);

    wait_phase(1'b1, 10);
    e0 = en_cnt;
    send(C_HALT, '0);
    wait_halted("halt_ph1", 10);
    chk("halt_ph1_en_cycles", en_cnt - e0, 1);
    chk("halt_ph1_phase", phase, 0);

    send(C_RUN, '0);
    wait_phase(1'b0, 10);
    e0 = en_cnt;
    send(C_HALT, '0);
    wait_halted("halt_ph0", 10);
    chk("halt_ph0_en_cycles", en_cnt - e0, 2);
    chk("halt_ph0_phase", phase, 0);

    r0 = retired;
    send(C_STEP, 12'd5);
    chk("step_busy_ready", dbg.cmd_ready, 0);
    send(C_RUN, '0);
    chk("step_busy_ready2", dbg.cmd_ready, 0);
    send(C_SET_BP, 12'h0AA);
    chk("drop_bp_en", dut.w_bp_en, 1);
    chk("drop_bp_addr", dut.u_bp.r_bp_addr, 12'h005);
    wait_halted("step5", 40);
    chk("step5_retired", retired, r0 + 16'd5);
    tick(5);
    chk("run_dropped", halted, 1);

    send(C_CLR_BP, '0);
    send(C_RUN, '0);
    wait_phase(1'b1, 10);
    chk("clrcnt_retiring", cpu_en, 1);
    send(C_CLR_CNT, '0);
    chk("clrcnt_wins", retired, 0);
    send(C_HALT, '0);
    wait_halted("clrcnt", 10);

    send(C_CLR_CNT, '0);
    send(C_SET_BP, 12'h300);
    send(C_STEP, 12'd5);
    k = 0;
    while (retired != 2 && k < 20) begin tick(1); k++; end
    chk("midstep_retired2", retired, 2);
    reset = 1'b0;
    @(negedge clock);
    chk("midstep_rst_en", cpu_en, 0);
    chk("midstep_rst_halted", halted, 1);
    chk("midstep_rst_retired", retired, 0);
    chk("midstep_rst_bp_en", dut.w_bp_en, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    tick(2);

    jumpy = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      c = 3'($urandom_range(7));
      if (c == C_SET_BP) a = PC_W'($urandom_range(15));
      else a = {4'($urandom_range(15)), 8'($urandom_range(6))};
      dbg.cmd_valid = ($urandom_range(3) == 0);
      dbg.cmd       = c;
      dbg.cmd_arg   = a;
      reset         = ($urandom_range(399) != 0);
      tick(1);
    end
    dbg.cmd_valid = 1'b0;
    reset = 1'b1;
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
